// File: rtl/ll_sc_pkg.sv
// rtl/ll_sc_pkg.sv - shared op encodings, channel state and sizing helpers for the LL/SC monitor
package ll_sc_pkg;

  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_LL = 2'b01,
    OP_SC = 2'b10,
    OP_SW = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESV = 1'b1
  } state_e;

  // Age counter width: enough to hold TMO, never narrower than one bit.
  function automatic int age_width(input int tmo);
    return (tmo > 0) ? $clog2(tmo + 1) : 1;
  endfunction

endpackage

// File: rtl/ll_sc_resv.sv
// rtl/ll_sc_resv.sv - one channel's reservation: IDLE/RESV state, granule tag and saturating age
module ll_sc_resv
  import ll_sc_pkg::*;
#(
  parameter int GW  = 30,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          drop,
  input  logic [GW-1:0] gran,
  output logic          resv,
  output logic [GW-1:0] tag
);

  localparam int AGW = age_width(TMO);
  localparam logic [AGW-1:0] AGE_LAST = AGW'((TMO > 0) ? TMO - 1 : 0);

  state_e         state, state_nxt;
  logic [GW-1:0]  tag_nxt;
  logic [AGW-1:0] age, age_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tag   <= '0;
      age   <= '0;
    end else begin
      state <= state_nxt;
      tag   <= tag_nxt;
      age   <= age_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tag_nxt   = tag;
    age_nxt   = age;
    if (state == RESV && TMO != 0 && age != '1) begin
      age_nxt = age + 1'b1;
    end
    // A new LL always wins: it replaces any existing reservation.
    if (set) begin
      state_nxt = RESV;
      tag_nxt   = gran;
      age_nxt   = '0;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RESV: begin
          if (drop) begin
            state_nxt = IDLE;
          end else if (TMO != 0 && age == AGE_LAST) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign resv = (state == RESV);

endmodule

// File: rtl/ll_sc_monitor.sv
// rtl/ll_sc_monitor.sv - multi-channel LL/SC reservation monitor: SC arbitration,
// store-driven invalidation and registered SC responses
module ll_sc_monitor
  import ll_sc_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int GB  = 2,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [2*NCH-1:0]  req_op,
  input  logic [AW*NCH-1:0] req_addr,
  input  logic [NCH-1:0]    clr,
  output logic [NCH-1:0]    mem_we,
  output logic [NCH-1:0]    rsp_valid,
  output logic [NCH-1:0]    rsp_ok,
  output logic [NCH-1:0]    resv_valid
);

  localparam int GW = AW - GB;

  logic [GW-1:0]  gran [NCH];
  logic [GW-1:0]  tag  [NCH];
  logic [NCH-1:0] resv, is_ll, is_sc, is_sw, sc_ok, store;
  logic [NCH-1:0] store_hit, ll_kill, set, drop;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      gran[i]  = req_addr[i*AW+GB +: GW];
      is_ll[i] = req_valid[i] && (req_op[2*i +: 2] == OP_LL);
      is_sc[i] = req_valid[i] && (req_op[2*i +: 2] == OP_SC);
      is_sw[i] = req_valid[i] && (req_op[2*i +: 2] == OP_SW);
    end
    // Any lower-index SC to the same granule takes priority, eligible or not.
    for (int i = 0; i < NCH; i++) begin
      sc_ok[i] = is_sc[i] && resv[i] && (tag[i] == gran[i]) && !clr[i];
      for (int j = 0; j < i; j++) begin
        if (is_sc[j] && (gran[j] == gran[i])) sc_ok[i] = 1'b0;
      end
      store[i] = is_sw[i] || sc_ok[i];
    end
    for (int i = 0; i < NCH; i++) begin
      store_hit[i] = 1'b0;
      ll_kill[i]   = 1'b0;
      for (int j = 0; j < NCH; j++) begin
        if (store[j] && (gran[j] == tag[i])) store_hit[i] = 1'b1;
        if (j != i && store[j] && (gran[j] == gran[i])) ll_kill[i] = 1'b1;
      end
      set[i]  = is_ll[i] && !clr[i] && !ll_kill[i];
      drop[i] = clr[i] || is_sc[i] || is_ll[i] || store_hit[i];
    end
    mem_we = reset ? store : '0;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ll_sc_resv #(
      .GW  (GW),
      .TMO (TMO)
    ) u_resv (
      .clk   (clk),
      .reset (reset),
      .set   (set[g]),
      .drop  (drop[g]),
      .gran  (gran[g]),
      .resv  (resv[g]),
      .tag   (tag[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_ok    <= '0;
    end else begin
      rsp_valid <= is_sc;
      rsp_ok    <= sc_ok;
    end
  end

  assign resv_valid = resv;

endmodule

// File: doc/ll_sc_monitor.md
LL_SC_MONITOR -- requirements
Module: ll_sc_monitor

Interface
REQ-001 Parameter NCH, default 2: number of requesting channels (1..8).
REQ-002 Parameter AW, default 32: byte-address width.
REQ-003 Parameter GB, default 2: granule offset bits; reservation compares addr[AW-1:GB].
REQ-004 Parameter TMO, default 255: reservation lifetime in cycles; 0 disables timeout.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-007 req_valid  in  NCH  channel i presents an operation this cycle.
REQ-008 req_op  in  2*NCH  per channel: 00 LW (no effect), 01 LL, 10 SC, 11 SW (plain store).
REQ-009 req_addr  in  AW*NCH  per-channel byte address.
REQ-010 clr  in  NCH  per-channel reservation kill (exception/eret).
REQ-011 mem_we  out  NCH  combinational store enable to data memory.
REQ-012 rsp_valid  out  NCH  registered; SC result available.
REQ-013 rsp_ok  out  NCH  registered; 1 = SC succeeded (value written to rt), 0 = failed.
REQ-014 resv_valid  out  NCH  registered per-channel reservation state (debug/visibility).

Function
REQ-015 Per-channel FSM, states IDLE and RESV; state, granule tag and age counter held per channel.
REQ-016 LL (valid, op 01): next state RESV, tag <= addr[AW-1:GB], age <= 0; an LL in RESV replaces the old reservation.
REQ-017 In RESV with TMO != 0, age increments each cycle; age == TMO-1 with no SC that cycle -> IDLE next cycle.
REQ-018 SC by channel i succeeds iff channel i is in RESV, the tag equals the SC granule, and no higher-priority conflict exists this cycle (REQ-021).
REQ-019 mem_we[i] = valid & (op==11 | (op==10 & success)), same cycle, no latency.
REQ-020 Any SC (pass or fail) returns channel i to IDLE; rsp_valid[i]=1 and rsp_ok[i]=success exactly one cycle later, each for one cycle.
REQ-021 Simultaneous SCs to one granule: lowest channel index succeeds if eligible; every other SC to that granule that cycle fails.
REQ-022 Any performed store (SW, or successful SC) by any channel to granule G clears every reservation on G, including the issuer's, effective next cycle.
REQ-023 An LL to G in the same cycle as another channel's store to G: the store wins; the LL channel ends IDLE.
REQ-024 clr[i] forces channel i to IDLE next cycle and overrides a same-cycle LL; a same-cycle SC from i fails.
REQ-025 LW and idle cycles (valid=0) leave all state unchanged except the age counter.
REQ-026 The age counter saturates and never wraps; it is width clog2(TMO+1) with a minimum of 1.
REQ-027 Different granules never interact; addresses differing only in bits [GB-1:0] are the same granule.

Reset
REQ-028 While reset=0 at a clock edge: all channels IDLE, tag=0, age=0, rsp_valid=0, rsp_ok=0, resv_valid=0.
REQ-029 While reset=0, mem_we is forced to 0.
REQ-030 Reset mid-reservation discards the reservation; a first SC after reset fails.

Structure
REQ-031 Shared package ll_sc_pkg holds the op encodings (OP_LW/OP_LL/OP_SC/OP_SW) and the state enum (IDLE, RESV).
REQ-032 Sub-module ll_sc_resv, instantiated NCH times by generate, holds one channel's FSM, tag and age.
REQ-033 Top level holds the priority/conflict logic, the store-invalidation fan-out and the response registers.

Verification
REQ-034 Ch0 LL 0x100, 3 idle cycles, SC 0x100 -> mem_we[0]=1 that cycle; rsp_ok[0]=1 next cycle; resv_valid[0]=0.
REQ-035 Ch0 LL 0x100, ch1 SW 0x102, ch0 SC 0x100 -> SW clears the reservation (same granule, GB=2); mem_we[0]=0; rsp_ok[0]=0.
REQ-036 Ch0 and ch1 both LL 0x200, then both SC 0x200 in the same cycle -> ch0 mem_we=1, rsp_ok=1; ch1 mem_we=0, rsp_ok=0.
REQ-037 TMO=4: LL 0x40, 4 idle cycles, SC 0x40 -> fail; repeat with 2 idle cycles -> success.
REQ-038 LL 0x80, reset=0 for one cycle, SC 0x80 -> fail; all outputs 0 during reset.
REQ-039 LL 0x80 with clr[0]=1 in the same cycle -> resv_valid[0]=0; a following SC 0x80 fails.
